store_dump_serialiser: RTL and testbench
========================================

Name: store_dump_serialiser

Overview:
Reads all 32 words of the Baby store through a synchronous read port and emits them as a bit-serial stream with valid/ready handshake, one line per word. Bit order matches the SNP text convention: bit 0 (LSB) goes first, i.e. the leftmost character of an SNP line. This block is the read-out counterpart of the generated program-memory loaders. It sits between the store and the host/UART link, and dumps store contents for comparison against .SNP files.

Parameters:
WORDS, 32, number of store lines dumped (addresses 0..WORDS-1)
WIDTH, 32, bits per store word
READ_LAT, 1, store read latency in cycles (mem_rd_en to mem_rdata valid); legal 1..4

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a dump; ignored while busy
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the final bit is accepted
mem_rd_en  out  1  store read strobe
mem_addr  out  5  store line address ($clog2(WORDS))
mem_rdata  in  WIDTH  store word, valid READ_LAT cycles after mem_rd_en
tx_bit  out  1  serial data bit
tx_valid  out  1  tx_bit valid
tx_ready  in  1  sink accepts bit when tx_valid && tx_ready
tx_sol  out  1  qualifies tx_bit as bit 0 of a line
tx_eol  out  1  qualifies tx_bit as bit WIDTH-1 of a line
tx_last  out  1  qualifies final bit of final line

Behaviour:
- Reset: busy, done, mem_rd_en, tx_valid, tx_bit, tx_sol, tx_eol and tx_last all 0; mem_addr 0. Reset mid-dump aborts immediately, discards in-flight read data, and returns to IDLE. No done pulse.
- FSM states:
  - IDLE: start → FETCH.
  - FETCH: mem_rd_en=1 for one cycle at mem_addr=line → WAIT.
  - WAIT: count READ_LAT cycles, capture mem_rdata → SHIFT.
  - SHIFT: emit bits of the current line.
  - FIN: done=1 for one cycle → IDLE.
- Latency: start sampled at edge k; busy=1 and mem_rd_en=1 (addr 0) in cycle k+1; with READ_LAT=1, tx_valid=1 with bit 0 of word 0 in cycle k+3.
- Prefetch: a one-entry word buffer. In the first SHIFT cycle of line n (n<WORDS-1), issue the read for line n+1 and capture it after READ_LAT cycles. When bit WIDTH-1 of line n is accepted and the buffer is full, load the shifter in the same edge. The next line starts the following cycle with no bubble. The buffer is always full in time because WIDTH > READ_LAT+1.
- Handshake:
  - tx_valid, once high, stays high and tx_bit/tx_sol/tx_eol/tx_last stay stable until accepted.
  - The shifter advances only on tx_valid && tx_ready.
  - tx_ready is allowed to be high while tx_valid=0, with no effect.
- Bit order: the first bit of each line is word[0], the last is word[WIDTH-1]. No inversion; the store word is transmitted as held.
- Counters:
  - The line counter wraps at WORDS; it never reads address ≥ WORDS.
  - The bit counter runs 0..WIDTH-1.
  - tx_last = tx_eol && line==WORDS-1.
- Completion: on acceptance of the tx_last bit, tx_valid drops the next cycle, done=1 that cycle (FIN), and busy=0 in the same cycle as done. A start in the FIN cycle is ignored; a start in the following IDLE cycle is accepted.
- Simultaneous events: reset dominates start. start while busy has no effect on state, counters or outputs.
- mem_addr holds its last value when mem_rd_en=0; the store must ignore it.

Decomposition:
- Shared package baby_pkg:
  - WORD_W=32, STORE_DEPTH=32, ADDR_W=5
  - typedef logic [WORD_W-1:0] word_t
  - typedef logic [ADDR_W-1:0] addr_t
  - enum dump_state_t {IDLE, FETCH, WAIT, SHIFT, FIN}
- One sub-module: dump_shifter. WIDTH-bit LSB-first parallel-load shift register with bit counter, valid/ready output stage and sol/eol flags. The parent owns the FSM, line counter, read-latency counter and prefetch buffer.

Test Plan:
- Store loaded with the FIB image, tx_ready tied 1, start pulsed:
  - line 1 (0x00000017) streams as 1,1,1,0,1 then 27 zeros;
  - line 22 (0xFFFFFFFF) streams as 32 ones;
  - line 31 (0x00000001) streams as 1 then 31 zeros with tx_last on its bit 31;
  - the full dump takes 1024 accepted bits with no gaps;
  - done pulses exactly once.
- Random tx_ready (≈40% duty), store of address-tagged words (word n = n | n<<16) → all 32 lines are bit-exact and tx_bit never changes while tx_valid && !tx_ready.
- READ_LAT=3 build, tx_ready=1 → first tx_valid at k+5; no bubble between lines (tx_eol followed directly by tx_sol); mem_rd_en pulses exactly 32 times.
- start re-pulsed at line 10 mid-dump → no restart, stream identical to an undisturbed dump.
- reset asserted on bit 7 of line 12 → next cycle all outputs 0, no done; a fresh start then dumps from line 0 correctly.
- start held high continuously → dumps repeat back-to-back, separated by FIN plus one IDLE cycle each, with done once per dump.

Source files
------------

// File: rtl/baby_pkg.sv
// Shared Baby store geometry and the dump FSM encoding.
package baby_pkg;

    localparam int WORD_W      = 32;
    localparam int STORE_DEPTH = 32;
    localparam int ADDR_W      = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        FIN   = 3'd4
    } dump_state_t;

endpackage

// File: rtl/dump_shifter.sv
// LSB-first parallel-load shifter with bit counter and sol/eol/last flags.
// Output registered one cycle after load; holds bit and flags while ready is low.
module dump_shifter
    import baby_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             last_line,
    input  logic             ready,
    output logic             tx_bit,
    output logic             valid,
    output logic             sol,
    output logic             eol,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bcnt;
    logic             vld;

    // A load may coincide with acceptance of the final bit, so it takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            bcnt <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            sreg <= data;
            bcnt <= '0;
            vld  <= 1'b1;
        end else if (vld && ready) begin
            if (bcnt == LAST_BIT) begin
                vld <= 1'b0;
            end else begin
                sreg <= sreg >> 1;
                bcnt <= bcnt + CW'(1);
            end
        end
    end

    assign valid  = vld;
    assign tx_bit = vld & sreg[0];
    assign sol    = vld && (bcnt == '0);
    assign eol    = vld && (bcnt == LAST_BIT);
    assign last   = eol && last_line;

endmodule

// File: rtl/store_dump_serialiser.sv
// Dumps all store lines as an LSB-first bit stream; first bit READ_LAT+2 cycles after start.
// One-word prefetch keeps lines back-to-back; the stream stalls bit-for-bit on tx_ready.
module store_dump_serialiser
    import baby_pkg::*;
#(
    parameter int WORDS    = STORE_DEPTH,
    parameter int WIDTH    = WORD_W,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [$clog2(WORDS)-1:0] mem_addr,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     tx_bit,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     tx_sol,
    output logic                     tx_eol,
    output logic                     tx_last
);
    localparam int AW = $clog2(WORDS);
    localparam logic [AW-1:0] LAST_LINE = AW'(WORDS - 1);
    localparam logic [2:0]    LAT_LAST  = 3'(READ_LAT - 1);

    dump_state_t      state;
    logic [AW-1:0]    line;
    logic [AW-1:0]    line_inc;
    logic [AW-1:0]    load_line;
    logic [2:0]       lat_cnt;
    logic             rd_pend;
    logic             rd_land;
    logic             first_cyc;
    logic [WIDTH-1:0] pf_buf;
    logic             pf_full;
    logic             accept;
    logic             load_wait;
    logic             load_buf;
    logic             load_sh;

    assign accept    = tx_valid && tx_ready;
    assign rd_land   = rd_pend && (lat_cnt == LAT_LAST);
    assign line_inc  = (line == LAST_LINE) ? '0 : line + AW'(1);
    assign load_wait = (state == WAIT) && rd_land;
    // Refill the shifter from the prefetch buffer on the edge that takes the last bit.
    assign load_buf  = (state == SHIFT) && pf_full && (!tx_valid || (accept && tx_eol));
    assign load_sh   = load_wait || load_buf;
    assign load_line = load_buf ? line_inc : line;

    assign busy      = (state == FETCH) || (state == WAIT) || (state == SHIFT);
    assign done      = (state == FIN);
    assign mem_rd_en = (state == FETCH) ||
                       ((state == SHIFT) && first_cyc && (line != LAST_LINE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            line      <= '0;
            mem_addr  <= '0;
            lat_cnt   <= '0;
            rd_pend   <= 1'b0;
            first_cyc <= 1'b0;
            pf_buf    <= '0;
            pf_full   <= 1'b0;
        end else begin
            first_cyc <= load_sh;

            if (mem_rd_en) begin
                rd_pend <= 1'b1;
                lat_cnt <= '0;
            end else if (rd_land) begin
                rd_pend <= 1'b0;
            end else if (rd_pend) begin
                lat_cnt <= lat_cnt + 3'd1;
            end

            if ((state == SHIFT) && rd_land) begin
                pf_buf  <= mem_rdata;
                pf_full <= 1'b1;
            end else if (load_buf) begin
                pf_full <= 1'b0;
            end

            // Address of the next prefetch is staged as each line enters the shifter.
            if (load_sh) begin
                line <= load_line;
                if (load_line != LAST_LINE) begin
                    mem_addr <= load_line + AW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        line     <= '0;
                        mem_addr <= '0;
                    end
                end
                FETCH:   state <= WAIT;
                WAIT:    if (rd_land) state <= SHIFT;
                SHIFT:   if (accept && tx_last) state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dump_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load_sh),
        .data      (load_buf ? pf_buf : mem_rdata),
        .last_line (line == LAST_LINE),
        .ready     (tx_ready),
        .tx_bit    (tx_bit),
        .valid     (tx_valid),
        .sol       (tx_sol),
        .eol       (tx_eol),
        .last      (tx_last)
    );

endmodule

// File: tb/tb_store_dump_serialiser.sv
// Scoreboard bench: READ_LAT=1 and READ_LAT=3 instances share one store image and sink.
module tb_store_dump_serialiser;

    logic       clk;
    logic       reset;
    logic       start_a, start_b;
    logic       tx_ready;
    logic       rand_ready;
    logic       sel;
    logic       mon_en;

    logic       a_busy, a_done, a_rd, a_bit, a_valid, a_sol, a_eol, a_last;
    logic [4:0] a_addr;
    logic [31:0] a_rdata;
    logic       b_busy, b_done, b_rd, b_bit, b_valid, b_sol, b_eol, b_last;
    logic [4:0] b_addr;
    logic [31:0] b_rdata;

    logic       m_busy, m_done, m_rd, m_bit, m_valid, m_sol, m_eol, m_last;
    logic [4:0] m_addr;

    logic [31:0] mem [32];
    logic [31:0] a_p1, b_p1, b_p2, b_p3;
    logic [31:0] rx_word [32];
    logic [3:0]  exp_q [$];
    logic [3:0]  want;
    logic [3:0]  prev_vec;
    logic        hold_prev, eol_prev;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt, done_cnt, rd_cnt, last_cnt, last_at;
    int first_valid, first_acc, last_acc;

    store_dump_serialiser #(.WORDS(32), .WIDTH(32), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
        .mem_rd_en(a_rd), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .tx_bit(a_bit), .tx_valid(a_valid), .tx_ready(tx_ready),
        .tx_sol(a_sol), .tx_eol(a_eol), .tx_last(a_last)
    );

    store_dump_serialiser #(.WORDS(32), .WIDTH(32), .READ_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .tx_bit(b_bit), .tx_valid(b_valid), .tx_ready(tx_ready),
        .tx_sol(b_sol), .tx_eol(b_eol), .tx_last(b_last)
    );

    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_rd    = sel ? b_rd    : a_rd;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_bit   = sel ? b_bit   : a_bit;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_sol   = sel ? b_sol   : a_sol;
    assign m_eol   = sel ? b_eol   : a_eol;
    assign m_last  = sel ? b_last  : a_last;

    // Store model: poison data whenever the read data is not expected to be used.
    always @(posedge clk) begin
        a_p1 <= a_rd ? mem[a_addr] : 32'hDEAD_BEEF;
        b_p1 <= b_rd ? mem[b_addr] : 32'hDEAD_BEEF;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign a_rdata = a_p1;
    assign b_rdata = b_p3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? ($urandom_range(0, 99) < 40) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks++;
        if (obs !== exp_val) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp_val);
        end
    endtask

    // Sink monitor: pops the scoreboard on every accepted bit.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (m_done) done_cnt++;
                if (m_rd) rd_cnt++;
                if (m_valid && first_valid < 0) first_valid = cyc;
                if (hold_prev)
                    check("hold_stable", 32'({m_valid, m_bit, m_sol, m_eol, m_last}),
                          32'({1'b1, prev_vec}));
                if (eol_prev)
                    check("no_bubble", 32'({m_valid, m_sol}), 32'd3);
                eol_prev  = 1'b0;
                hold_prev = m_valid && !tx_ready;
                prev_vec  = {m_bit, m_sol, m_eol, m_last};
                if (m_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", 32'd1, 32'd0);
                    end else begin
                        want = exp_q.pop_front();
                        check("bit", 32'({m_bit, m_sol, m_eol, m_last}), 32'(want));
                    end
                    rx_word[(acc_cnt / 32) % 32][acc_cnt % 32] = m_bit;
                    if (m_last) begin
                        last_cnt++;
                        last_at = acc_cnt;
                    end
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    eol_prev = m_eol && !m_last;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic mon_clear();
        acc_cnt = 0; done_cnt = 0; rd_cnt = 0; last_cnt = 0; last_at = -1;
        first_valid = -1; first_acc = -1; last_acc = -1;
        hold_prev = 1'b0; eol_prev = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 32; n++) rx_word[n] = '0;
    endtask

    task automatic push_dump();
        for (int l = 0; l < 32; l++)
            for (int i = 0; i < 32; i++)
                exp_q.push_back({mem[l][i], i == 0, i == 31, (i == 31) && (l == 31)});
    endtask

    task automatic load_fib();
        for (int n = 0; n < 32; n++) mem[n] = $urandom;
        mem[1]  = 32'h0000_0017;
        mem[22] = 32'hFFFF_FFFF;
        mem[31] = 32'h0000_0001;
    endtask

    task automatic load_tagged();
        for (int n = 0; n < 32; n++) mem[n] = 32'(n) | (32'(n) << 16);
    endtask

    task automatic start_with_latency(input string tag, input int lat);
        @(posedge clk); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check({tag, "_k1_fetch"}, 32'({m_busy, m_rd, m_addr}), 32'({1'b1, 1'b1, 5'd0}));
        check({tag, "_k1_novalid"}, 32'(m_valid), 32'd0);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_wait_novalid"}, 32'(m_valid), 32'd0);
        end
        @(negedge clk);
        check({tag, "_first_bit"}, 32'({m_valid, m_sol, m_bit}), 32'({1'b1, 1'b1, mem[0][0]}));
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (m_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int i = 0;
        while (acc_cnt < n && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        check("wait_acc_reached", 32'(acc_cnt >= n), 32'd1);
    endtask

    task automatic end_checks(input string tag, input int nbits, input int ndone);
        repeat (3) @(negedge clk);
        check({tag, "_accepted"}, 32'(acc_cnt), 32'(nbits));
        check({tag, "_done_count"}, 32'(done_cnt), 32'(ndone));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle_after"}, 32'({m_busy, m_valid}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        rand_ready = 1'b0; sel = 1'b0; mon_en = 1'b0;
        mon_clear();
        load_fib();
        repeat (3) @(posedge clk);
        #1 start_a = 1'b1;
        @(negedge clk);
        check("reset_outs_a", 32'({a_busy, a_done, a_rd, a_valid, a_bit, a_sol, a_eol, a_last, a_addr}), 32'd0);
        check("reset_outs_b", 32'({b_busy, b_done, b_rd, b_valid, b_bit, b_sol, b_eol, b_last, b_addr}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; start_a = 1'b0;
        @(negedge clk);
        check("reset_beats_start", 32'({a_busy, a_rd}), 32'd0);

        // FIB image, sink always ready
        mon_clear(); load_fib(); push_dump(); mon_en = 1'b1;
        start_with_latency("fib", 1);
        wait_done("fib", 2000);
        end_checks("fib", 1024, 1);
        check("fib_line1", rx_word[1], 32'h0000_0017);
        check("fib_line22", rx_word[22], 32'hFFFF_FFFF);
        check("fib_line31", rx_word[31], 32'h0000_0001);
        check("fib_last_count", 32'(last_cnt), 32'd1);
        check("fib_last_pos", 32'(last_at), 32'd1023);
        check("fib_span", 32'(last_acc - first_acc + 1), 32'd1024);
        check("fib_no_lead_gap", 32'(first_acc - first_valid), 32'd0);

        // Tagged image under random backpressure
        mon_clear(); load_tagged(); push_dump(); rand_ready = 1'b1;
        start_with_latency("rand", 1);
        wait_done("rand", 6000);
        rand_ready = 1'b0;
        end_checks("rand", 1024, 1);
        for (int n = 0; n < 32; n++)
            check("rand_line", rx_word[n], 32'(n) | (32'(n) << 16));

        // Three-cycle store latency
        sel = 1'b1;
        mon_clear(); load_tagged(); push_dump();
        start_with_latency("lat3", 3);
        wait_done("lat3", 2000);
        end_checks("lat3", 1024, 1);
        check("lat3_reads", 32'(rd_cnt), 32'd32);
        check("lat3_span", 32'(last_acc - first_acc + 1), 32'd1024);
        sel = 1'b0;

        // start re-pulsed mid-dump
        mon_clear(); load_fib(); push_dump();
        start_with_latency("restart", 1);
        wait_acc(10 * 32 + 5, 2000);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done("restart", 2000);
        end_checks("restart", 1024, 1);

        // Reset on bit 7 of line 12
        mon_clear(); load_fib(); push_dump();
        start_with_latency("abort", 1);
        wait_acc(12 * 32 + 8, 2000);
        reset = 1'b1;
        mon_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_outs", 32'({m_busy, m_done, m_rd, m_valid, m_bit, m_sol, m_eol, m_last, m_addr}), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'({m_done, m_busy}), 32'd0);
        end
        mon_clear(); load_tagged(); push_dump(); mon_en = 1'b1;
        start_with_latency("after_abort", 1);
        wait_done("after_abort", 2000);
        end_checks("after_abort", 1024, 1);

        // start held high: back-to-back dumps
        mon_clear(); load_fib(); push_dump(); push_dump();
        @(posedge clk); #1 start_a = 1'b1;
        wait_done("held1", 2000);
        @(negedge clk);
        check("held_idle_gap", 32'({m_busy, m_valid, m_done}), 32'd0);
        @(negedge clk);
        check("held_refetch", 32'({m_busy, m_rd, m_addr}), 32'({1'b1, 1'b1, 5'd0}));
        wait_done("held2", 2000);
        start_a = 1'b0;
        end_checks("held", 2048, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
